// File: rtl/cm_arbiter_hs.sv
// cm_arbiter_hs: weighted ready/valid arbiter with a committed grant and round-robin tie-break.
// Optional starvation override is enabled by defining CM_ARBITER_HS_STARVE_EN.

package cm_pkg;
  typedef enum logic {ARB_MIN = 1'b0, ARB_MAX = 1'b1} t_arb_algo;

  function automatic int sclog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

module cm_arbiter_hs
  import cm_pkg::*;
#(
  parameter int        DCNT       = 4,
  parameter int        DWIDTH     = 8,
  parameter t_arb_algo ALGO       = ARB_MIN,
  parameter int        STARVE_LIM = 8,
  parameter int        IDX_WIDTH  = sclog2(DCNT)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [DCNT-1:0]             i_req,
  input  logic [DCNT-1:0][DWIDTH-1:0] i_weight,
  input  logic                        i_rdy,
  output logic                        o_vld,
  output logic [IDX_WIDTH-1:0]        o_gnt,
  output logic [DCNT-1:0]             o_gnt_oh,
  output logic [DWIDTH-1:0]           o_weight,
  output logic                        o_starve
);

  // state   | meaning
  // S_IDLE  | no grant outstanding, o_vld=0
  // S_GRANT | grant presented and held until i_rdy accepts it
  typedef enum logic {S_IDLE, S_GRANT} t_state;

  t_state               state;
  logic [IDX_WIDTH-1:0] rr;
  logic                 accept;
  logic [IDX_WIDTH-1:0] start_idx;
  logic [DCNT-1:0]      cand;
  logic                 sel_starve;
  logic                 sel_found;
  logic [IDX_WIDTH-1:0] sel_idx;
  logic [IDX_WIDTH-1:0] cur;
  logic [DWIDTH-1:0]    sel_w;
  logic [DCNT-1:0]      sel_oh;
  int                   scan;

  assign accept = (state == S_GRANT) && i_rdy;

  function automatic logic better(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
    return (ALGO == ARB_MIN) ? (a < b) : (a > b);
  endfunction

  // On accept the scan starts just past the accepted index, so it can only win again if strictly better.
  always_comb begin
    start_idx = rr;
    if (accept) start_idx = (o_gnt == IDX_WIDTH'(DCNT-1)) ? '0 : o_gnt + 1'b1;
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_w     = '0;
    scan      = 0;
    cur       = '0;
    for (int k = 0; k < DCNT; k++) begin
      scan = int'(start_idx) + k;
      if (scan >= DCNT) scan = scan - DCNT;
      cur = IDX_WIDTH'(scan);
      if (cand[cur] && (!sel_found || better(i_weight[cur], sel_w))) begin
        sel_found = 1'b1;
        sel_idx   = cur;
        sel_w     = i_weight[cur];
      end
    end
  end

  assign sel_oh = {{(DCNT-1){1'b0}}, 1'b1} << sel_idx;

`ifdef CM_ARBITER_HS_STARVE_EN
  localparam int CW = sclog2(STARVE_LIM + 1);

  logic [DCNT-1:0][CW-1:0] cnt_q;
  logic [DCNT-1:0][CW-1:0] cnt_nxt;
  logic [DCNT-1:0]         starved;

  // Re-arbitration on accept must see the post-accept counts.
  always_comb begin
    cnt_nxt = cnt_q;
    starved = '0;
    for (int i = 0; i < DCNT; i++) begin
      if (accept) begin
        if (!i_req[i] || (o_gnt == IDX_WIDTH'(i))) cnt_nxt[i] = '0;
        else if (cnt_q[i] != CW'(STARVE_LIM))      cnt_nxt[i] = cnt_q[i] + 1'b1;
      end
      starved[i] = i_req[i] && (cnt_nxt[i] == CW'(STARVE_LIM));
    end
    sel_starve = |starved;
    cand       = sel_starve ? starved : i_req;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_nxt;
  end
`else
  assign cand       = i_req;
  assign sel_starve = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      rr       <= '0;
      o_vld    <= 1'b0;
      o_gnt    <= '0;
      o_gnt_oh <= '0;
      o_weight <= '0;
      o_starve <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|i_req) begin
            state    <= S_GRANT;
            o_vld    <= 1'b1;
            o_gnt    <= sel_idx;
            o_gnt_oh <= sel_oh;
            o_weight <= sel_w;
            o_starve <= sel_starve;
          end
        end
        S_GRANT: begin
          if (i_rdy) begin
            rr <= start_idx;
            if (|i_req) begin
              o_gnt    <= sel_idx;
              o_gnt_oh <= sel_oh;
              o_weight <= sel_w;
              o_starve <= sel_starve;
            end else begin
              state    <= S_IDLE;
              o_vld    <= 1'b0;
              o_gnt_oh <= '0;
              o_starve <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cm_arbiter_hs.sv
// Bench for cm_arbiter_hs: directed vector table, starvation sequence, and randomized run vs a reference model.
module tb_cm_arbiter_hs;
  import cm_pkg::*;

  localparam int LIM = 3;

  logic             i_clk;
  logic             i_rst;
  logic [3:0]       i_req;
  logic [3:0][7:0]  i_weight;
  logic             i_rdy;

  logic             vld_min, vld_max, st_min, st_max;
  logic [1:0]       gnt_min, gnt_max;
  logic [3:0]       oh_min, oh_max;
  logic [7:0]       w_min, w_max;

  cm_arbiter_hs #(.DCNT(4), .DWIDTH(8), .ALGO(ARB_MIN), .STARVE_LIM(LIM)) u_min (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_weight(i_weight), .i_rdy(i_rdy),
    .o_vld(vld_min), .o_gnt(gnt_min), .o_gnt_oh(oh_min), .o_weight(w_min), .o_starve(st_min));

  cm_arbiter_hs #(.DCNT(4), .DWIDTH(8), .ALGO(ARB_MAX), .STARVE_LIM(LIM)) u_max (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_weight(i_weight), .i_rdy(i_rdy),
    .o_vld(vld_max), .o_gnt(gnt_max), .o_gnt_oh(oh_max), .o_weight(w_max), .o_starve(st_max));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state, index 0 = min instance, 1 = max instance
  int m_vld [2];
  int m_gnt [2];
  int m_w   [2];
  int m_st  [2];
  int m_rr  [2];
  int m_cnt [2][4];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int inst, input bit is_max, input logic rst,
                            input logic [3:0] req, input logic [3:0][7:0] w, input logic rdy);
    bit pool [4];
    bit any_starved;
    int best, wi, idx;
    if (rst) begin
      m_vld[inst] = 0; m_gnt[inst] = 0; m_w[inst] = 0; m_st[inst] = 0; m_rr[inst] = 0;
      for (int i = 0; i < 4; i++) m_cnt[inst][i] = 0;
      return;
    end
    if (m_vld[inst] != 0 && rdy == 1'b0) return;
    if (m_vld[inst] != 0) begin
      m_rr[inst] = (m_gnt[inst] + 1) % 4;
      for (int i = 0; i < 4; i++) begin
        if (i == m_gnt[inst] || !req[i]) m_cnt[inst][i] = 0;
        else if (m_cnt[inst][i] < LIM)   m_cnt[inst][i] = m_cnt[inst][i] + 1;
      end
    end
    if (req == 4'b0000) begin
      m_vld[inst] = 0;
      m_st[inst]  = 0;
      return;
    end
    any_starved = 1'b0;
`ifdef CM_ARBITER_HS_STARVE_EN
    for (int i = 0; i < 4; i++) if (req[i] && m_cnt[inst][i] == LIM) any_starved = 1'b1;
`endif
    for (int i = 0; i < 4; i++)
      pool[i] = any_starved ? (req[i] && m_cnt[inst][i] == LIM) : req[i];
    best = is_max ? -1 : 256;
    for (int i = 0; i < 4; i++) begin
      wi = int'(w[i]);
      if (pool[i] && (is_max ? (wi > best) : (wi < best))) best = wi;
    end
    for (int k = 3; k >= 0; k--) begin
      idx = (m_rr[inst] + k) % 4;
      if (pool[idx] && int'(w[idx]) == best) m_gnt[inst] = idx;
    end
    m_vld[inst] = 1;
    m_w[inst]   = int'(w[m_gnt[inst]]);
    m_st[inst]  = any_starved ? 1 : 0;
  endtask

  task automatic check_model();
    chk("mdl.min.vld", int'(vld_min), m_vld[0]);
    chk("mdl.min.oh", int'(oh_min), (m_vld[0] != 0) ? (1 << m_gnt[0]) : 0);
    chk("mdl.min.starve", int'(st_min), m_st[0]);
    if (m_vld[0] != 0) begin
      chk("mdl.min.gnt", int'(gnt_min), m_gnt[0]);
      chk("mdl.min.weight", int'(w_min), m_w[0]);
    end
    chk("mdl.max.vld", int'(vld_max), m_vld[1]);
    chk("mdl.max.oh", int'(oh_max), (m_vld[1] != 0) ? (1 << m_gnt[1]) : 0);
    chk("mdl.max.starve", int'(st_max), m_st[1]);
    if (m_vld[1] != 0) begin
      chk("mdl.max.gnt", int'(gnt_max), m_gnt[1]);
      chk("mdl.max.weight", int'(w_max), m_w[1]);
    end
  endtask

  task automatic apply(input logic rst, input logic [3:0] req, input logic [3:0][7:0] w, input logic rdy);
    i_rst    = rst;
    i_req    = req;
    i_weight = w;
    i_rdy    = rdy;
    @(posedge i_clk);
    model_step(0, 1'b0, rst, req, w, rdy);
    model_step(1, 1'b1, rst, req, w, rdy);
    #1;
    check_model();
  endtask

  typedef struct {
    logic            rst;
    logic [3:0]      req;
    logic [3:0][7:0] w;
    logic            rdy;
    logic            e_vld;
    int              e_gmin;
    int              e_gmax;
    int              e_wmin;
    int              e_wmax;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [3:0] req, logic [3:0][7:0] w, logic rdy,
                              logic ev, int gmin, int gmax, int wmin, int wmax);
    vec_t v;
    v.rst = rst; v.req = req; v.w = w; v.rdy = rdy; v.e_vld = ev;
    v.e_gmin = gmin; v.e_gmax = gmax; v.e_wmin = wmin; v.e_wmax = wmax;
    return v;
  endfunction

  function automatic logic [7:0] rand_w();
    case ($urandom % 4)
      0:       return 8'd0;
      1:       return 8'hFF;
      2:       return 8'(1 + $urandom % 3);
      default: return 8'($urandom);
    endcase
  endfunction

  vec_t tbl[$];
  logic [3:0][7:0] wa, wb, wff, wz, wc, w7, ws, wr;
  int exp_smin_g[5], exp_smax_g[5], exp_s_st[5];
  int exp_oh;

  initial begin
    wa  = {8'd40, 8'd10, 8'd70, 8'd25};
    wb  = {8'd1, 8'd250, 8'd0, 8'd99};
    wff = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    wz  = '0;
    wc  = {8'd9, 8'd9, 8'd9, 8'd25};
    w7  = {8'd7, 8'd7, 8'd7, 8'd7};
    ws  = {8'd0, 8'd0, 8'd200, 8'd5};

    // weighted pick, then committed grant held while weights change and req[1] drops
    tbl.push_back(mk(1, 4'b0000, wz, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, wa, 1, 1, 2, 1, 10, 70));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 4'b1101, wb, 0, 1, 2, 1, 10, 70));
    tbl.push_back(mk(0, 4'b1101, wa, 1, 1, 2, 3, 10, 40));
    // all-max weights, then all-zero weights: pure round-robin
    tbl.push_back(mk(1, 4'b1111, wff, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 4'b1111, wff, 1, 1, i % 4, i % 4, 255, 255));
    tbl.push_back(mk(1, 4'b1111, wz, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 4'b1111, wz, 1, 1, i % 4, i % 4, 0, 0));
    // single requester with i_rdy toggling, then drop to idle
    tbl.push_back(mk(1, 4'b0000, wc, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0001, wc, 1, 1, 0, 0, 25, 25));
    tbl.push_back(mk(0, 4'b0001, wc, 1, 1, 0, 0, 25, 25));
    tbl.push_back(mk(0, 4'b0001, wc, 0, 1, 0, 0, 25, 25));
    tbl.push_back(mk(0, 4'b0001, wc, 1, 1, 0, 0, 25, 25));
    tbl.push_back(mk(0, 4'b0000, wc, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, wc, 0, 0, 0, 0, 0, 0));
    // reset mid-grant on index 3, then restart from rr=0
    tbl.push_back(mk(1, 4'b0000, w7, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1000, w7, 0, 1, 3, 3, 7, 7));
    tbl.push_back(mk(1, 4'b1111, w7, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, w7, 0, 1, 0, 0, 7, 7));

    foreach (tbl[r]) begin
      apply(tbl[r].rst, tbl[r].req, tbl[r].w, tbl[r].rdy);
      chk("tbl.min.vld", int'(vld_min), int'(tbl[r].e_vld));
      chk("tbl.max.vld", int'(vld_max), int'(tbl[r].e_vld));
      exp_oh = tbl[r].e_vld ? (1 << tbl[r].e_gmin) : 0;
      chk("tbl.min.oh", int'(oh_min), exp_oh);
      exp_oh = tbl[r].e_vld ? (1 << tbl[r].e_gmax) : 0;
      chk("tbl.max.oh", int'(oh_max), exp_oh);
      if (tbl[r].e_vld || tbl[r].rst) begin
        chk("tbl.min.gnt", int'(gnt_min), tbl[r].e_gmin);
        chk("tbl.max.gnt", int'(gnt_max), tbl[r].e_gmax);
        chk("tbl.min.weight", int'(w_min), tbl[r].e_wmin);
        chk("tbl.max.weight", int'(w_max), tbl[r].e_wmax);
      end
    end

    // starvation sequence: two requesters with very different weights
`ifdef CM_ARBITER_HS_STARVE_EN
    exp_smin_g = '{0, 0, 0, 1, 0};
    exp_smax_g = '{1, 1, 1, 0, 1};
    exp_s_st   = '{0, 0, 0, 1, 0};
`else
    exp_smin_g = '{0, 0, 0, 0, 0};
    exp_smax_g = '{1, 1, 1, 1, 1};
    exp_s_st   = '{0, 0, 0, 0, 0};
`endif
    apply(1, 4'b0000, ws, 0);
    for (int g = 0; g < 5; g++) begin
      apply(0, 4'b0011, ws, 1);
      chk("starve.min.gnt", int'(gnt_min), exp_smin_g[g]);
      chk("starve.max.gnt", int'(gnt_max), exp_smax_g[g]);
      chk("starve.min.flag", int'(st_min), exp_s_st[g]);
      chk("starve.max.flag", int'(st_max), exp_s_st[g]);
    end

    // randomized run checked against the reference model inside apply()
    apply(1, 4'b0000, wz, 0);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) wr[i] = rand_w();
      apply(($urandom % 64) == 0,
            (($urandom % 8) == 0) ? 4'b0000 : 4'($urandom),
            wr,
            ($urandom % 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
